acc_arb: RTL
============

# acc_arb

Two-requester round-robin arbiter and sequencer for the single-cycle CPU accumulator write port. It samples requests from two producers, selects one per cycle and drives the accumulator's `CE`/`IN` pair from registered outputs. With the optional lock feature, a requester can keep ownership for a bounded burst of consecutive accumulator loads. It sits directly in front of the `acc` instance, and its `ACC_CE`/`ACC_IN` outputs connect straight to `acc.CE`/`acc.IN`.

## Interface
- `WIDTH`, default 4: data width; must match the accumulator `WIDTH`.
- `MAX_BURST`, default 4: maximum consecutive grants to one locked owner, range 2..15.

- `CLK`  in  1: clock; everything is updated on the rising edge.
- `RST_N`  in  1: reset, synchronous, active-low.
- `REQ0`, `REQ1`  in  1: request from producer 0 or 1; held high until a grant is seen.
- `DATA0`, `DATA1`  in  `WIDTH`: value to load; must be valid whenever the matching `REQn` is high.
- `LOCK0`, `LOCK1`  in  1: burst request; meaningful only with `ACC_ARB_LOCK_EN`.
- `GNT0`, `GNT1`  out  1: registered grant; high for each cycle whose `ACC_IN` came from that requester.
- `ACC_CE`  out  1: registered accumulator enable.
- `ACC_IN`  out  `WIDTH`: registered accumulator data.

## Operation
- State machine:
  - States are `IDLE`, `G0` and `G1`.
  - `Gn` means `GNTn=1`, `ACC_CE=1` and `ACC_IN` = the `DATAn` value sampled at the entering edge.
  - `IDLE` means all outputs are 0; `ACC_IN` is forced to 0 and does not hold its last value.
- Internal registers:
  - Priority pointer `ptr`, 1 bit, reset value 0 (requester 0 preferred).
  - Burst counter `bcnt`, 4 bits, reset value 0.
- Next state at each edge:
  - Eligible set E = {n : `REQn`=1} minus the current owner.
  - The current owner stays in E only if it is in a valid burst continuation (see Configuration).
  - If E is empty, go to `IDLE`.
  - If E has one member, grant it.
  - If E has two members, grant requester `ptr`.
- On entering `Gn` from any other state: `ptr` ← not n, and `bcnt` ← 1.
- On a burst continuation (`Gn` to `Gn`): `bcnt` increments and `ptr` is unchanged.
- Without a lock, a requester whose grant is high in the current cycle is masked for that cycle. The requester drops `REQ` (or presents new data) at that edge, so no duplicate load occurs.
- Without a lock, one requester therefore receives at most one grant every 2 cycles. Two active requesters alternate every cycle.
- Simultaneous requests in `IDLE` are resolved by `ptr`.
- Requests that rise while another requester is granted are served at the next edge, with no starvation.
- Reset: `RST_N`=0 at an edge forces `IDLE`, `ptr`=0 and `bcnt`=0, and all outputs go to 0 regardless of `REQ`/`LOCK`. This includes reset in the middle of a burst; the grant is aborted and no partial state is retained.

## Timing
- Arbiter latency: 1 cycle. A request sampled at edge k produces `GNT`/`ACC_CE`/`ACC_IN` valid from edge k through edge k+1.
- The accumulator captures at edge k+1, so `acc.OUT` shows the data after edge k+1. Request to visible result is 2 edges.
- A grant is a single-cycle pulse per load. During a burst, the grant stays high and each cycle loads the `DATAn` value sampled at the preceding edge.
- Reset takes effect at the first edge with `RST_N`=0. The first grant can occur at the first edge with `RST_N`=1.

## Configuration
- Macro: `ACC_ARB_LOCK_EN`.
- Defined: in state `Gn`, if `REQn`=1, `LOCKn`=1 and `bcnt` < `MAX_BURST`, the next state is `Gn` (burst continuation).
  - When `bcnt` = `MAX_BURST`, the owner is masked at that edge; the other requester is granted if requesting, otherwise the state goes to `IDLE`.
  - After a forced release, the owner can win again no earlier than 2 edges later.
- Not defined: `LOCK0`/`LOCK1` are ignored and the ports remain present. `bcnt` logic is compiled out, and pure round-robin applies.

## Test plan
- Reset:
  - Stimulus: `RST_N`=0 for 2 edges with `REQ0`=`REQ1`=1.
  - Response: all outputs are 0 during reset; the first edge after release gives `GNT0`=1 (`ptr`=0).
- Single load:
  - Stimulus: `REQ0`=1, `DATA0`=4'b0101 at edge k; `REQ0` is dropped after the grant.
  - Response: `GNT0`=1, `ACC_CE`=1, `ACC_IN`=0101 for one cycle; `acc.OUT`=0101 after edge k+1; then `IDLE`.
- Contention:
  - Stimulus: `REQ0`=`REQ1`=1 held, `DATA0`=0011, `DATA1`=1100.
  - Response: grants G0,G1,G0,G1; `ACC_IN` alternates 0011/1100; `ACC_CE` stays continuously 1.
- Lone holder:
  - Stimulus: `REQ0` held high, no lock.
  - Response: `GNT0` follows the pattern 1,0,1,0, with no back-to-back loads.
- Burst (macro defined, `MAX_BURST`=4):
  - Stimulus: `REQ0`=`LOCK0`=1 and `REQ1`=1 held.
  - Response: `GNT0` for 4 consecutive cycles, then `GNT1` for 1 cycle, then `GNT0` again.
  - Without the macro, the same stimulus gives plain alternation.
- Mid-burst reset:
  - Stimulus: `RST_N`=0 during the 2nd burst cycle.
  - Response: the next cycle is `IDLE` with all outputs 0; after release, `GNT0` wins with `bcnt` restarting at 1.

Source files
------------

// File: rtl/acc_arb.sv
// Round-robin arbiter for the two-producer accumulator write port, with registered CE/IN/grant outputs.
// Define ACC_ARB_LOCK_EN to let a requester hold the port for up to MAX_BURST consecutive loads.
module acc_arb #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] DATA0,
    input  logic [WIDTH-1:0] DATA1,
    input  logic             LOCK0,
    input  logic             LOCK1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             ACC_CE,
    output logic [WIDTH-1:0] ACC_IN
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             gnt0_q, gnt1_q, ce_q;
    logic [WIDTH-1:0] in_q;
    logic             cont0, cont1;
    logic             elig0, elig1;

`ifdef ACC_ARB_LOCK_EN
    logic [3:0] bcnt_q, bcnt_d;

    // The owner keeps the port only while it still locks and has burst budget left.
    assign cont0 = (state_q == G0) && REQ0 && LOCK0 && (bcnt_q < 4'(MAX_BURST));
    assign cont1 = (state_q == G1) && REQ1 && LOCK1 && (bcnt_q < 4'(MAX_BURST));
`else
    logic unused_lock;

    assign unused_lock = LOCK0 | LOCK1;
    assign cont0       = 1'b0;
    assign cont1       = 1'b0;
`endif

    // A requester granted this cycle is masked so its held REQ is not loaded twice.
    assign elig0 = REQ0 && (state_q != G0);
    assign elig1 = REQ1 && (state_q != G1);

    always_comb begin
        state_d = IDLE;
        ptr_d   = ptr_q;
        if (cont0) begin
            state_d = G0;
        end else if (cont1) begin
            state_d = G1;
        end else if (elig0 && elig1) begin
            state_d = ptr_q ? G1 : G0;
        end else if (elig0) begin
            state_d = G0;
        end else if (elig1) begin
            state_d = G1;
        end
        if ((state_d == G0) && (state_q != G0)) begin
            ptr_d = 1'b1;
        end else if ((state_d == G1) && (state_q != G1)) begin
            ptr_d = 1'b0;
        end
    end

`ifdef ACC_ARB_LOCK_EN
    always_comb begin
        bcnt_d = bcnt_q;
        if (state_d != IDLE) begin
            bcnt_d = (state_d == state_q) ? (bcnt_q + 4'd1) : 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bcnt_q <= 4'd0;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            ce_q    <= 1'b0;
            in_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt0_q  <= (state_d == G0);
            gnt1_q  <= (state_d == G1);
            ce_q    <= (state_d != IDLE);
            case (state_d)
                G0:      in_q <= DATA0;
                G1:      in_q <= DATA1;
                default: in_q <= '0;
            endcase
        end
    end

    assign GNT0   = gnt0_q;
    assign GNT1   = gnt1_q;
    assign ACC_CE = ce_q;
    assign ACC_IN = in_q;

endmodule
